// File: rtl/controlador_rodadas.sv
// Round sequencer driving an external 4-bit counter; Moore outputs, one-cycle state transitions.
// No backpressure: iniciar is honoured only in INICIAL/FIM, pausa freezes counting.
// Optional watchdog enabled by CONTROLADOR_RODADAS_TIMEOUT_EN.
module controlador_rodadas #(
  parameter int RODADAS = 4
) (
  input  logic       clock,
  input  logic       clr,
  input  logic       iniciar,
  input  logic       pausa,
  input  logic [3:0] preset,
  input  logic       rco,
  output logic       cnt_clr,
  output logic       cnt_ld,
  output logic       cnt_ent,
  output logic       cnt_enp,
  output logic [3:0] rodada,
  output logic       pronto,
  output logic       erro,
  output logic [2:0] estado
);

  typedef enum logic [2:0] {
    INICIAL = 3'd0,
    PREPARA = 3'd1,
    CONTA   = 3'd2,
    PAUSA   = 3'd3,
    RECARGA = 3'd4,
    FIM     = 3'd5
  } estado_t;

  localparam logic [3:0] RODADAS_L = 4'(RODADAS);

  estado_t    estado_q, estado_d;
  logic [3:0] rodada_q, rodada_d;
  logic       timeout;

  // preset is loaded by the counter itself; the sequencer never needs its value
  logic unused_preset;
  assign unused_preset = ^preset;

`ifdef CONTROLADOR_RODADAS_TIMEOUT_EN
  localparam logic [4:0] WD_LAST = 5'd19;

  logic [4:0] wd_q, wd_d;
  logic       erro_q, erro_d;

  // WD_LAST is the count before this CONTA cycle, so the 20th cycle trips it
  assign timeout = (wd_q == WD_LAST);

  always_comb begin
    wd_d   = wd_q;
    erro_d = erro_q;
    case (estado_q)
      PREPARA, RECARGA: wd_d = '0;
      CONTA: begin
        wd_d = wd_q + 5'd1;
        if (!rco && timeout) erro_d = 1'b1;
      end
      FIM: if (iniciar) erro_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge clr) begin
    if (!clr) begin
      wd_q   <= '0;
      erro_q <= 1'b0;
    end else begin
      wd_q   <= wd_d;
      erro_q <= erro_d;
    end
  end

  assign erro = erro_q;
`else
  assign timeout = 1'b0;
  assign erro    = 1'b0;
`endif

  always_comb begin
    estado_d = estado_q;
    rodada_d = rodada_q;
    case (estado_q)
      INICIAL: begin
        if (iniciar) begin
          estado_d = PREPARA;
          rodada_d = '0;
        end
      end
      PREPARA: estado_d = CONTA;
      CONTA: begin
        // rco wins over both the watchdog and pausa
        if (rco) begin
          rodada_d = rodada_q + 4'd1;
          estado_d = ((rodada_q + 4'd1) == RODADAS_L) ? FIM : RECARGA;
        end else if (timeout) begin
          estado_d = FIM;
        end else if (pausa) begin
          estado_d = PAUSA;
        end
      end
      PAUSA: if (!pausa) estado_d = CONTA;
      RECARGA: estado_d = CONTA;
      FIM: begin
        if (iniciar) begin
          estado_d = PREPARA;
          rodada_d = '0;
        end
      end
      default: estado_d = INICIAL;
    endcase
  end

  always_ff @(posedge clock or negedge clr) begin
    if (!clr) begin
      estado_q <= INICIAL;
      rodada_q <= '0;
    end else begin
      estado_q <= estado_d;
      rodada_q <= rodada_d;
    end
  end

  always_comb begin
    cnt_clr = 1'b0;
    cnt_ld  = 1'b1;
    cnt_ent = 1'b0;
    cnt_enp = 1'b0;
    pronto  = 1'b0;
    case (estado_q)
      PREPARA, RECARGA: begin
        cnt_clr = 1'b1;
        cnt_ld  = 1'b0;
      end
      CONTA: begin
        cnt_clr = 1'b1;
        cnt_ent = 1'b1;
        cnt_enp = 1'b1;
      end
      PAUSA: begin
        cnt_clr = 1'b1;
        cnt_ent = 1'b1;
      end
      FIM: begin
        cnt_clr = 1'b1;
        pronto  = 1'b1;
      end
      default: ;
    endcase
  end

  assign estado = estado_q;
  assign rodada = rodada_q;

endmodule

// File: tb/tb_controlador_rodadas.sv
// Bench for controlador_rodadas: two instances (4 and 2 rounds) against a behavioural model.
module tb_controlador_rodadas;

  localparam int S_INI = 0, S_PRE = 1, S_CON = 2, S_PAU = 3, S_REC = 4, S_FIM = 5;
`ifdef CONTROLADOR_RODADAS_TIMEOUT_EN
  localparam bit TIMEOUT = 1'b1;
`else
  localparam bit TIMEOUT = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       clr, iniciar, pausa, rco;
  logic [3:0] preset;

  logic       clr0, ld0, ent0, enp0, pr0, err0;
  logic       clr1, ld1, ent1, enp1, pr1, err1;
  logic [3:0] rod0, rod1;
  logic [2:0] est0, est1;

  int checks = 0;
  int failures = 0;

  // behavioural model: one entry per instance
  int m_st  [2];
  int m_rod [2];
  int m_wd  [2];
  bit m_err [2];
  int rr    [2] = '{4, 2};
  // {cnt_clr, cnt_ld, cnt_ent, cnt_enp, pronto} per state, straight from the output table
  logic [4:0] out_tbl [0:5] = '{5'b01000, 5'b10000, 5'b11110, 5'b11100, 5'b10000, 5'b11001};

  controlador_rodadas #(.RODADAS(4)) dut0 (
    .clock(clock), .clr(clr), .iniciar(iniciar), .pausa(pausa), .preset(preset), .rco(rco),
    .cnt_clr(clr0), .cnt_ld(ld0), .cnt_ent(ent0), .cnt_enp(enp0),
    .rodada(rod0), .pronto(pr0), .erro(err0), .estado(est0)
  );

  controlador_rodadas #(.RODADAS(2)) dut1 (
    .clock(clock), .clr(clr), .iniciar(iniciar), .pausa(pausa), .preset(preset), .rco(rco),
    .cnt_clr(clr1), .cnt_ld(ld1), .cnt_ent(ent1), .cnt_enp(enp1),
    .rodada(rod1), .pronto(pr1), .erro(err1), .estado(est1)
  );

  always #5 clock = ~clock;

  function automatic logic [12:0] obs_vec(int k);
    if (k == 0) return {est0, rod0, err0, clr0, ld0, ent0, enp0, pr0};
    return {est1, rod1, err1, clr1, ld1, ent1, enp1, pr1};
  endfunction

  function automatic logic [12:0] exp_vec(int k);
    return {3'(m_st[k]), 4'(m_rod[k]), m_err[k], out_tbl[m_st[k]]};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = S_INI; m_rod[k] = 0; m_wd[k] = 0; m_err[k] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      case (m_st[k])
        S_INI: if (iniciar) begin m_st[k] = S_PRE; m_rod[k] = 0; end
        S_PRE: begin m_st[k] = S_CON; m_wd[k] = 0; end
        S_CON: begin
          m_wd[k]++;
          if (rco) begin
            m_rod[k]++;
            m_st[k] = (m_rod[k] == rr[k]) ? S_FIM : S_REC;
          end else if (TIMEOUT && m_wd[k] == 20) begin
            m_st[k] = S_FIM; m_err[k] = 1'b1;
          end else if (pausa) begin
            m_st[k] = S_PAU;
          end
        end
        S_PAU: if (!pausa) m_st[k] = S_CON;
        S_REC: begin m_st[k] = S_CON; m_wd[k] = 0; end
        S_FIM: if (iniciar) begin m_st[k] = S_PRE; m_rod[k] = 0; m_err[k] = 1'b0; end
        default: m_st[k] = S_INI;
      endcase
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    clr = 1'b0;
    model_reset();
    #2;
    clr = 1'b1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs_vec(k) !== 13'b000_0000_0_01000) begin
        failures++;
        $display("FAIL reset dut%0d got=%b exp=%b", k, obs_vec(k), 13'b000_0000_0_01000);
      end
    end
  endtask

  task automatic test_full_run();
    do_reset();
    preset = 4'd0; pausa = 1'b0; rco = 1'b0; iniciar = 1'b1;
    step();
    iniciar = 1'b0;
    checks++;
    if ({est0, ld0} !== {3'd1, 1'b0}) begin
      failures++; $display("FAIL prepara est=%0d ld=%b exp est=1 ld=0", est0, ld0);
    end
    for (int r = 0; r < 4; r++) begin
      step();
      for (int c = 0; c < 15; c++) step();
      rco = 1'b1;
      step();
      rco = 1'b0;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_vec(k) !== exp_vec(k)) begin
          failures++;
          $display("FAIL full_run r%0d dut%0d got=%h exp=%h", r, k, obs_vec(k), exp_vec(k));
        end
      end
    end
    checks++;
    if ({pr0, rod0, est0} !== {1'b1, 4'd4, 3'd5}) begin
      failures++; $display("FAIL full_run_end pronto=%b rodada=%0d est=%0d exp 1/4/5", pr0, rod0, est0);
    end
  endtask

  task automatic test_preset5();
    do_reset();
    preset = 4'd5; pausa = 1'b0; rco = 1'b1; iniciar = 1'b1;
    step();
    iniciar = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_vec(k) !== exp_vec(k)) begin
          failures++;
          $display("FAIL preset5 c%0d dut%0d got=%h exp=%h", i, k, obs_vec(k), exp_vec(k));
        end
      end
    end
    checks++;
    if ({est1, rod1, pr1} !== {3'd5, 4'd2, 1'b1}) begin
      failures++; $display("FAIL preset5_fim est=%0d rodada=%0d pronto=%b exp 5/2/1", est1, rod1, pr1);
    end
    rco = 1'b0;
  endtask

  task automatic test_pausa();
    do_reset();
    preset = 4'd0; pausa = 1'b0; rco = 1'b0; iniciar = 1'b1;
    step();
    iniciar = 1'b0;
    for (int i = 0; i < 6; i++) step();
    pausa = 1'b1;
    for (int i = 0; i < 7; i++) begin
      rco = 1'($urandom_range(0, 1));
      if (i == 0) rco = 1'b0;
      step();
      checks++;
      if ({est0, enp0, rod0} !== {3'd3, 1'b0, 4'd0}) begin
        failures++; $display("FAIL pausa c%0d est=%0d enp=%b rodada=%0d exp 3/0/0", i, est0, enp0, rod0);
      end
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_vec(k) !== exp_vec(k)) begin
          failures++;
          $display("FAIL pausa_model c%0d dut%0d got=%h exp=%h", i, k, obs_vec(k), exp_vec(k));
        end
      end
    end
    pausa = 1'b0; rco = 1'b0;
    step();
    checks++;
    if ({est0, enp0} !== {3'd2, 1'b1}) begin
      failures++; $display("FAIL pausa_exit est=%0d enp=%b exp 2/1", est0, enp0);
    end
  endtask

  task automatic test_rco_pausa();
    rco = 1'b1; pausa = 1'b1;
    step();
    rco = 1'b0; pausa = 1'b0;
    checks++;
    if ({est0, rod0} !== {3'd4, 4'd1}) begin
      failures++; $display("FAIL rco_pausa est=%0d rodada=%0d exp 4/1", est0, rod0);
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs_vec(k) !== exp_vec(k)) begin
        failures++; $display("FAIL rco_pausa_model dut%0d got=%h exp=%h", k, obs_vec(k), exp_vec(k));
      end
    end
  endtask

  task automatic test_clr_mid();
    step();
    step();
    clr = 1'b0;
    model_reset();
    #2;
    checks++;
    if ({est0, rod0, clr0, est1, rod1, clr1} !== {3'd0, 4'd0, 1'b0, 3'd0, 4'd0, 1'b0}) begin
      failures++;
      $display("FAIL clr_mid est0=%0d rod0=%0d clr0=%b est1=%0d rod1=%0d clr1=%b exp zeros",
               est0, rod0, clr0, est1, rod1, clr1);
    end
    #1;
    clr = 1'b1;
    iniciar = 1'b1;
    step();
    iniciar = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs_vec(k) !== exp_vec(k) || obs_vec(k) !== 13'b001_0000_0_10000) begin
        failures++; $display("FAIL clr_restart dut%0d got=%b exp=%b", k, obs_vec(k), 13'b001_0000_0_10000);
      end
    end
  endtask

  task automatic test_timeout();
    do_reset();
    preset = 4'd0; pausa = 1'b0; rco = 1'b0; iniciar = 1'b1;
    step();
    iniciar = 1'b0;
    step();
`ifdef CONTROLADOR_RODADAS_TIMEOUT_EN
    for (int i = 0; i < 19; i++) step();
    checks++;
    if ({est0, err0} !== {3'd2, 1'b0}) begin
      failures++; $display("FAIL timeout_early est=%0d erro=%b exp 2/0", est0, err0);
    end
    step();
    checks++;
    if ({est0, err0, pr0, rod0} !== {3'd5, 1'b1, 1'b1, 4'd0}) begin
      failures++; $display("FAIL timeout est=%0d erro=%b pronto=%b rodada=%0d exp 5/1/1/0", est0, err0, pr0, rod0);
    end
`else
    for (int i = 0; i < 25; i++) step();
    checks++;
    if ({est0, err0, pr0} !== {3'd2, 1'b0, 1'b0}) begin
      failures++; $display("FAIL no_timeout est=%0d erro=%b pronto=%b exp 2/0/0", est0, err0, pr0);
    end
`endif
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs_vec(k) !== exp_vec(k)) begin
        failures++; $display("FAIL timeout_model dut%0d got=%h exp=%h", k, obs_vec(k), exp_vec(k));
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      iniciar = ($urandom_range(0, 7) == 0);
      pausa   = ($urandom_range(0, 3) == 0);
      rco     = ($urandom_range(0, 9) == 0);
      preset  = 4'($urandom_range(0, 15));
      step();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_vec(k) !== exp_vec(k)) begin
          failures++;
          $display("FAIL random c%0d dut%0d got=%h exp=%h", i, k, obs_vec(k), exp_vec(k));
        end
      end
    end
    iniciar = 1'b0; pausa = 1'b0; rco = 1'b0;
  endtask

  initial begin
    clr = 1'b0; iniciar = 1'b0; pausa = 1'b0; rco = 1'b0; preset = 4'd0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    test_reset();
    clr = 1'b1;
    test_full_run();
    test_preset5();
    test_pausa();
    test_rco_pausa();
    test_clr_mid();
    test_timeout();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
